// File: rtl/load_store_unit_if.sv
// Request/response handshake plus Data_Memory port bundle for the load/store unit.
// No logic inside; the unit is the slave, the pipeline/memory side is the master.
// Backpressure is carried by req_ready and resp_ready.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] ALU_Result;
   logic [31:0] WriteMemData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadMemData;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  resp_ready, ReadMemData,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output ALU_Result, WriteMemData, MemWrite, MemRead
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output resp_ready, ReadMemData,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  ALU_Result, WriteMemData, MemWrite, MemRead
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store initiator for a word-wide memory; sub-word stores are read-modify-write.
// Latency accept->resp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
// One transaction at a time: req_ready only in IDLE; response held until resp_ready.
module load_store_unit #(
   parameter int MEM_WORDS = 16,
   parameter int IDX_W     = 4
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic        signed_q;
   logic [31:0] wdata_q;
   logic [31:0] alu_q;
   logic [31:0] wmem_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic        err_d;

   // Extract the addressed byte/halfword from a memory word and extend it.
   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic sg);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   load_ext = {{24{sg & b[7]}}, b};
         2'b01:   load_ext = {{16{sg & h[15]}}, h};
         default: load_ext = w;
      endcase
   endfunction

   // Replace the addressed lane of the old memory word with the store data.
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                               input logic [1:0] lane, input logic [1:0] sz);
      logic [31:0] r;
      r = w;
      case (sz)
         2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
         2'b01: begin
            if (lane[1]) r[31:16] = wd[15:0];
            else         r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      store_merge = r;
   endfunction

   // Illegal size, misalignment, or word index beyond the memory.
   always_comb begin
      err_d = 1'b0;
      if (bus.req_size == 2'b11)                                    err_d = 1'b1;
      if (bus.req_size == 2'b01 && bus.req_addr[0])                 err_d = 1'b1;
      if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)      err_d = 1'b1;
      if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS)                 err_d = 1'b1;
   end

   // Transaction FSM; every memory-facing output is a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lane_q       <= '0;
         size_q       <= '0;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         wdata_q      <= '0;
         alu_q        <= '0;
         wmem_q       <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  lane_q       <= bus.req_addr[1:0];
                  size_q       <= bus.req_size;
                  write_q      <= bus.req_write;
                  signed_q     <= bus.req_signed;
                  wdata_q      <= bus.req_wdata;
                  alu_q        <= {{(32-IDX_W){1'b0}}, bus.req_addr[IDX_W+1:2]};
                  resp_rdata_q <= '0;
                  resp_err_q   <= err_d;
                  if (err_d) begin
                     state_q <= RESP;
                  end else if (bus.req_write && bus.req_size == 2'b10) begin
                     wmem_q      <= bus.req_wdata;
                     mem_write_q <= 1'b1;
                     state_q     <= WRITE;
                  end else begin
                     mem_read_q <= 1'b1;
                     state_q    <= READ;
                  end
               end
            end
            READ: begin
               mem_read_q <= 1'b0;
               if (write_q) begin
                  wmem_q      <= store_merge(bus.ReadMemData, wdata_q, lane_q, size_q);
                  mem_write_q <= 1'b1;
                  state_q     <= WRITE;
               end else begin
                  resp_rdata_q <= load_ext(bus.ReadMemData, lane_q, size_q, signed_q);
                  state_q      <= RESP;
               end
            end
            WRITE: begin
               mem_write_q <= 1'b0;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  alu_q   <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.resp_valid   = (state_q == RESP);
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.resp_err     = resp_err_q;
   assign bus.ALU_Result   = alu_q;
   assign bus.WriteMemData = wmem_q;
   assign bus.MemWrite     = mem_write_q;
   assign bus.MemRead      = mem_read_q;

endmodule
